// File: rtl/unsigned_approx_div_pkg.sv
// Shared types and helpers for the approximate unsigned sequential divider.
// Defaults match the 8x8 multiplier bank at approximation level 2.
package unsigned_approx_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DEF_W = 8;
   localparam int DEF_L = 2;

   // Quotient would not fit in W bits: high dividend half already reaches the divisor.
   function automatic logic ovf_check(input logic [31:0] hi, input logic [31:0] dvsr);
      return (dvsr != 32'd0) && (hi >= dvsr);
   endfunction

endpackage

// File: rtl/unsigned_approx_divider_seq_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module approx_div_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] r_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] r_out,
   output logic         qbit
);

   logic [W:0] t_s;

   assign t_s  = {r_in, bit_in};
   assign qbit = (t_s >= {1'b0, divisor});
   // The difference is below the divisor, so the low W bits of a W-bit subtract are exact.
   assign r_out = qbit ? (t_s[W-1:0] - divisor) : t_s[W-1:0];

endmodule

// File: rtl/unsigned_approx_divider_seq.sv
// Iterative restoring divider inverting the approximate WxW multipliers; the low L
// dividend bits are dropped at accept to mirror the multipliers' truncation.
module unsigned_approx_divider_seq
   import unsigned_approx_div_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int L = DEF_L
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder,
   output logic           div_zero,
   output logic           ovf
);

   localparam int               CW         = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0]    LAST_STEP  = CW'(W - 1);
   localparam logic [2*W-1:0]   TRUNC_MASK = {(2*W){1'b1}} << L;

   div_state_t    state_r, state_n_s;
   logic [W-1:0]  r_r, low_r, q_r, div_r;
   logic [CW-1:0] cnt_r;
   logic [W-1:0]  quotient_r, remainder_r;
   logic          div_zero_r, ovf_r, out_valid_r;

   logic [2*W-1:0] dividend_t_s;
   logic           div_zero_s, ovf_s, qbit_s;
   logic [W-1:0]   r_next_s, q_next_s;

   assign dividend_t_s = dividend & TRUNC_MASK;
   assign div_zero_s   = (divisor == {W{1'b0}});
   assign ovf_s        = ovf_check(32'(dividend_t_s[2*W-1:W]), 32'(divisor));
   assign q_next_s     = {q_r[W-2:0], qbit_s};

   approx_div_step #(.W(W)) u_step (
      .r_in    (r_r),
      .bit_in  (low_r[W-1]),
      .divisor (div_r),
      .r_out   (r_next_s),
      .qbit    (qbit_s)
   );

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign quotient  = quotient_r;
   assign remainder = remainder_r;
   assign div_zero  = div_zero_r;
   assign ovf       = ovf_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Next-state logic; degenerate divisions skip BUSY and finish in one cycle.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (div_zero_s || ovf_s) begin
                  state_n_s = DONE;
               end else begin
                  state_n_s = BUSY;
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == LAST_STEP) begin
               state_n_s = DONE;
            end else begin
               state_n_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = DONE;
            end
         end
         default: state_n_s = IDLE;
      endcase
   end

   // Operand capture, restoring iteration and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r         <= {W{1'b0}};
         low_r       <= {W{1'b0}};
         q_r         <= {W{1'b0}};
         div_r       <= {W{1'b0}};
         cnt_r       <= {CW{1'b0}};
         quotient_r  <= {W{1'b0}};
         remainder_r <= {W{1'b0}};
         div_zero_r  <= 1'b0;
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  div_r <= divisor;
                  cnt_r <= {CW{1'b0}};
                  r_r   <= dividend_t_s[2*W-1:W];
                  low_r <= dividend_t_s[W-1:0];
                  q_r   <= {W{1'b0}};
                  if (div_zero_s) begin
                     quotient_r  <= {W{1'b1}};
                     remainder_r <= dividend_t_s[W-1:0];
                     div_zero_r  <= 1'b1;
                     ovf_r       <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else if (ovf_s) begin
                     quotient_r  <= {W{1'b1}};
                     remainder_r <= {W{1'b0}};
                     div_zero_r  <= 1'b0;
                     ovf_r       <= 1'b1;
                     out_valid_r <= 1'b1;
                  end else begin
                     quotient_r  <= {W{1'b0}};
                     remainder_r <= {W{1'b0}};
                     div_zero_r  <= 1'b0;
                     ovf_r       <= 1'b0;
                     out_valid_r <= 1'b0;
                  end
               end
            end
            BUSY: begin
               r_r   <= r_next_s;
               low_r <= {low_r[W-2:0], 1'b0};
               q_r   <= q_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == LAST_STEP) begin
                  quotient_r  <= q_next_s;
                  remainder_r <= r_next_s;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: out_valid_r <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_approx_divider_seq.sv
// Scoreboard bench: two divider instances (L=0 and L=2) driven with directed and random
// operations, checked against an arithmetic reference model by a decoupled monitor.
module tb_unsigned_approx_divider_seq;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
      int         acc;
      int         lat;
   } exp_t;

   logic             clk;
   logic [1:0]       rst_n;
   logic [1:0]       in_valid, in_ready, out_valid, out_ready, div_zero, ovf;
   logic [1:0][15:0] dividend;
   logic [1:0][7:0]  divisor, quotient, remainder;
   logic [1:0]       auto_rdy, man_rdy;

   exp_t exp_q[2][$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   logic [1:0]       prev_v = 2'b00;
   logic [1:0]       hold = 2'b00;
   logic [1:0][17:0] held;

   unsigned_approx_divider_seq #(.W(8), .L(0)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .dividend(dividend[0]), .divisor(divisor[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .quotient(quotient[0]), .remainder(remainder[0]),
      .div_zero(div_zero[0]), .ovf(ovf[0]));

   unsigned_approx_divider_seq #(.W(8), .L(2)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .dividend(dividend[1]), .divisor(divisor[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .quotient(quotient[1]), .remainder(remainder[1]),
      .div_zero(div_zero[1]), .ovf(ovf[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++)
         out_ready[k] <= auto_rdy[k] ? ($urandom_range(0, 3) != 0) : man_rdy[k];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int q, input int r, input bit dz, input bit ov, input int lat);
      exp_t e;
      e.q = 8'(q); e.r = 8'(r); e.dz = dz; e.ov = ov; e.acc = 0; e.lat = lat;
      return e;
   endfunction

   // Reference: floor/mod of the truncated dividend, saturating on divide-by-zero or overflow.
   function automatic exp_t model(input int k, input int d, input int v);
      int lv = (k == 0) ? 0 : 2;
      int dt = d & ~((1 << lv) - 1);
      if (v == 0) return mk(255, dt % 256, 1'b1, 1'b0, 1);
      if (dt / 256 >= v) return mk(255, 0, 1'b0, 1'b1, 1);
      return mk(dt / v, dt % v, 1'b0, 1'b0, 9);
   endfunction

   task automatic issue(input int k, input logic [15:0] d, input logic [7:0] v,
                        input exp_t e, input bit push, output int acc);
      int t = 0;
      exp_t ee = e;
      acc = 0;
      @(negedge clk);
      in_valid[k] = 1'b1;
      dividend[k] = d;
      divisor[k]  = v;
      while (!in_ready[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready[k]) begin
         n_checks++;
         n_errors++;
         $display("FAIL dut%0d_accept_timeout: actual=in_ready 0 required=in_ready 1", k);
      end else begin
         acc = cyc;
         if (push) begin
            ee.acc = cyc;
            exp_q[k].push_back(ee);
         end
      end
      @(negedge clk);
      in_valid[k] = 1'b0;
   endtask

   task automatic rand_run(input int k, input int n);
      int acc, v, d, sel;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         sel = $urandom_range(0, 9);
         v = (sel == 0) ? 0 : $urandom_range(1, 255);
         if (sel <= 2) d = $urandom_range(0, 65535);
         else d = v * $urandom_range(0, 255) + $urandom_range(0, v - 1);
         issue(k, 16'(d), 8'(v), model(k, d, v), 1'b1, acc);
      end
   endtask

   // Monitor: latency on out_valid rise, hold stability under back-pressure, result on handshake.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (out_valid[k] && !prev_v[k] && exp_q[k].size() > 0)
            check($sformatf("dut%0d_latency", k), 32'(cyc - exp_q[k][0].acc), 32'(exp_q[k][0].lat));
         if (out_valid[k] && hold[k])
            check($sformatf("dut%0d_hold_stable", k),
                  32'({quotient[k], remainder[k], div_zero[k], ovf[k]}), 32'(held[k]));
         if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL dut%0d_unexpected_result: actual=q 0x%0h required=no output", k, quotient[k]);
            end else begin
               exp_t e;
               e = exp_q[k].pop_front();
               check($sformatf("dut%0d_result(q,r,dz,ovf)", k),
                     32'({quotient[k], remainder[k], div_zero[k], ovf[k]}),
                     32'({e.q, e.r, e.dz, e.ov}));
            end
         end
         prev_v[k] <= out_valid[k];
         hold[k]   <= out_valid[k] && !out_ready[k];
         held[k]   <= {quotient[k], remainder[k], div_zero[k], ovf[k]};
      end
   end

   initial begin
      int acc, t;
      rst_n = 2'b00; in_valid = 2'b00; dividend = '0; divisor = '0;
      auto_rdy = 2'b00; man_rdy = 2'b11;
      #2;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("dut%0d_reset_out_valid", k), 32'(out_valid[k]), 32'd0);
         check($sformatf("dut%0d_reset_in_ready", k), 32'(in_ready[k]), 32'd1);
         check($sformatf("dut%0d_reset_outputs", k),
               32'({quotient[k], remainder[k], div_zero[k], ovf[k]}), 32'd0);
      end
      repeat (3) @(negedge clk);
      rst_n = 2'b11;

      // Directed cases with hand-derived results.
      issue(0, 16'd1003, 8'd7,   mk(143, 2, 0, 0, 9),     1'b1, acc);
      issue(0, 16'hFE01, 8'd255, mk(255, 0, 0, 0, 9),     1'b1, acc);
      issue(0, 16'h1234, 8'd0,   mk(255, 8'h34, 1, 0, 1), 1'b1, acc);
      issue(0, 16'h0800, 8'd8,   mk(255, 0, 0, 1, 1),     1'b1, acc);
      issue(0, 16'h07FF, 8'd8,   mk(255, 7, 0, 0, 9),     1'b1, acc);
      issue(1, 16'd1003, 8'd7,   mk(142, 6, 0, 0, 9),     1'b1, acc);
      issue(1, 16'hFE01, 8'd255, mk(254, 254, 0, 0, 9),   1'b1, acc);
      issue(1, 16'h1237, 8'd0,   mk(255, 8'h34, 1, 0, 1), 1'b1, acc);
      issue(1, 16'd3,    8'd1,   mk(0, 0, 0, 0, 9),       1'b1, acc);

      // Back-pressure on the L=2 instance: results held, new requests ignored.
      repeat (12) @(negedge clk);
      man_rdy[1] = 1'b0;
      repeat (2) @(negedge clk);
      issue(1, 16'd1003, 8'd7, mk(142, 6, 0, 0, 9), 1'b1, acc);
      t = 0;
      while (!out_valid[1] && t < 30) begin
         @(negedge clk);
         t++;
      end
      check("bp_out_valid_seen", 32'(out_valid[1]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", 32'(in_ready[1]), 32'd0);
         check("bp_out_valid_held", 32'(out_valid[1]), 32'd1);
         in_valid[1] = 1'b1; dividend[1] = 16'hFFFF; divisor[1] = 8'd1;
      end
      in_valid[1] = 1'b0;
      man_rdy[1]  = 1'b1;
      issue(1, 16'hFE01, 8'd255, mk(254, 254, 0, 0, 9), 1'b1, acc);

      // Reset in the middle of the iteration discards the operation.
      repeat (12) @(negedge clk);
      issue(0, 16'd500, 8'd3, mk(0, 0, 0, 0, 0), 1'b0, acc);
      t = 0;
      while (cyc - acc < 5 && t < 20) begin
         @(negedge clk);
         t++;
      end
      rst_n[0] = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
      check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", 32'(in_ready[0]), 32'd1);
      check("postrst_out_valid", 32'(out_valid[0]), 32'd0);
      issue(0, 16'd1003, 8'd7, mk(143, 2, 0, 0, 9), 1'b1, acc);

      // Random traffic with random output back-pressure on both instances.
      auto_rdy = 2'b11;
      fork
         rand_run(0, 3000);
         rand_run(1, 3000);
      join

      t = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
